writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_pkg.sv | 29 ++
 rtl/writeback_queue.sv | 74 +++++++
 rtl/writeback_arbiter.sv | 165 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// ============================================================================
//  Module      : writeback_pkg
//  Description : Shared writeback record field widths, functional-unit codes
//                and a helper that sizes the packed channel record.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package writeback_pkg;

    localparam int WB_DATA_WIDTH      = 64;
    localparam int WB_REG_ADDR_WIDTH  = 6;
    localparam int WB_UNIT_CODE_WIDTH = 2;

    typedef enum logic [1:0] {
        UNIT_FX     = 2'd0,
        UNIT_FP     = 2'd1,
        UNIT_LDST   = 2'd2,
        UNIT_BRANCH = 2'd3
    } unit_code_e;

    // Packed record: code, reg1 enable, reg2 enable, two addresses, two values.
    function automatic int wb_rec_width(input int code_w, input int addr_w, input int data_w);
        return code_w + 2 + 2 * addr_w + 2 * data_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_queue.sv
// ============================================================================
//  Module      : writeback_queue
//  Description : Per-channel FIFO of packed writeback records. Pointers wrap
//                naturally because the depth is a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_queue
    import writeback_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int WIDTH       = 8,
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [WIDTH-1:0] r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clock_i) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; flush discards everything held.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(QUEUE_DEPTH));

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Collects writeback records from NUM_UNITS functional-unit
//                channels into per-channel queues and forwards one record per
//                cycle, round-robin, through a registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int NUM_UNITS       = 4,
    parameter int QUEUE_DEPTH     = 4,
    parameter int DATA_WIDTH      = WB_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH  = WB_REG_ADDR_WIDTH,
    parameter int UNIT_CODE_WIDTH = WB_UNIT_CODE_WIDTH,
    localparam int PEND_WIDTH     = $clog2(NUM_UNITS * QUEUE_DEPTH + 2)
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                flush_i,
    input  logic [NUM_UNITS-1:0]                unitValid_i,
    output logic [NUM_UNITS-1:0]                unitReady_o,
    input  logic [NUM_UNITS*UNIT_CODE_WIDTH-1:0] unitCode_i,
    input  logic [NUM_UNITS-1:0]                unitReg1En_i,
    input  logic [NUM_UNITS-1:0]                unitReg2En_i,
    input  logic [NUM_UNITS*REG_ADDR_WIDTH-1:0] unitReg1Addr_i,
    input  logic [NUM_UNITS*REG_ADDR_WIDTH-1:0] unitReg2Addr_i,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]     unitReg1Val_i,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]     unitReg2Val_i,
    output logic                                wbValid_o,
    input  logic                                wbReady_i,
    output logic [UNIT_CODE_WIDTH-1:0]          functionalUnitCode_o,
    output logic                                reg1WritebackEnable_o,
    output logic                                reg2WritebackEnable_o,
    output logic [REG_ADDR_WIDTH-1:0]           reg1WritebackAddress_o,
    output logic [REG_ADDR_WIDTH-1:0]           reg2WritebackAddress_o,
    output logic [DATA_WIDTH-1:0]               reg1WritebackVal_o,
    output logic [DATA_WIDTH-1:0]               reg2WritebackVal_o,
    output logic [PEND_WIDTH-1:0]               pending_o
);

    localparam int REC_W    = wb_rec_width(UNIT_CODE_WIDTH, REG_ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);
    localparam int GNT_W    = $clog2(NUM_UNITS);
    localparam int V2_LSB   = 0;
    localparam int V1_LSB   = DATA_WIDTH;
    localparam int A2_LSB   = 2 * DATA_WIDTH;
    localparam int A1_LSB   = A2_LSB + REG_ADDR_WIDTH;
    localparam int EN2_BIT  = A1_LSB + REG_ADDR_WIDTH;
    localparam int EN1_BIT  = EN2_BIT + 1;
    localparam int CODE_LSB = EN1_BIT + 1;

    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic [NUM_UNITS-1:0] w_empty;
    logic [NUM_UNITS-1:0] w_full;
    logic [REC_W-1:0]     w_head  [NUM_UNITS];
    logic [CNT_W-1:0]     w_count [NUM_UNITS];

    logic [GNT_W-1:0]     r_last;
    logic                 r_valid;
    logic [REC_W-1:0]     r_rec;

    logic [GNT_W-1:0]     w_gidx;
    logic [GNT_W-1:0]     w_cand;
    logic                 w_found;
    logic                 w_load;
    logic [PEND_WIDTH-1:0] w_pend;

    // Output stage accepts a new record when empty or when its record is taken.
    assign w_load  = ~r_valid | wbReady_i;
    assign w_found = ~&w_empty;

    generate
        for (genvar n = 0; n < NUM_UNITS; n++) begin : g_chan
            logic [REC_W-1:0] w_rec_in;

            assign w_rec_in = {unitCode_i[n*UNIT_CODE_WIDTH +: UNIT_CODE_WIDTH],
                               unitReg1En_i[n], unitReg2En_i[n],
                               unitReg1Addr_i[n*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                               unitReg2Addr_i[n*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                               unitReg1Val_i[n*DATA_WIDTH +: DATA_WIDTH],
                               unitReg2Val_i[n*DATA_WIDTH +: DATA_WIDTH]};

            // Ready depends on queue occupancy only, so no path from wbReady_i.
            assign unitReady_o[n] = ~w_full[n];
            // Records with no enabled write are handshaked but never stored.
            assign w_push[n] = unitValid_i[n] & ~w_full[n] & ~flush_i
                             & (unitReg1En_i[n] | unitReg2En_i[n]);
            assign w_pop[n]  = w_load & w_found & ~flush_i & (w_gidx == GNT_W'(n));

            writeback_queue #(
                .QUEUE_DEPTH (QUEUE_DEPTH),
                .WIDTH       (REC_W)
            ) u_queue (
                .clock_i (clock_i),
                .reset_i (reset_i),
                .flush_i (flush_i),
                .i_push  (w_push[n]),
                .i_data  (w_rec_in),
                .i_pop   (w_pop[n]),
                .o_data  (w_head[n]),
                .o_count (w_count[n]),
                .o_empty (w_empty[n]),
                .o_full  (w_full[n])
            );
        end
    endgenerate

    // Round-robin pick: scan from farthest to nearest after lastGrant so the
    // nearest non-empty channel is the final (winning) assignment.
    always_comb begin
        w_gidx = r_last;
        w_cand = r_last;
        for (int i = NUM_UNITS; i >= 1; i--) begin
            w_cand = GNT_W'((int'(r_last) + i) % NUM_UNITS);
            if (!w_empty[w_cand]) begin
                w_gidx = w_cand;
            end
        end
    end

    // Output register with grant tracking; first grant after reset is channel 0.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_valid <= 1'b0;
            r_rec   <= '0;
            r_last  <= GNT_W'(NUM_UNITS - 1);
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_rec   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_rec   <= w_head[w_gidx];
                r_last  <= w_gidx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Records held: every queue entry plus the occupied output register.
    always_comb begin
        w_pend = PEND_WIDTH'(r_valid);
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_pend = w_pend + PEND_WIDTH'(w_count[i]);
        end
    end

    assign pending_o              = w_pend;
    assign wbValid_o              = r_valid;
    assign functionalUnitCode_o   = r_rec[CODE_LSB +: UNIT_CODE_WIDTH];
    assign reg1WritebackEnable_o  = r_rec[EN1_BIT];
    assign reg2WritebackEnable_o  = r_rec[EN2_BIT];
    assign reg1WritebackAddress_o = r_rec[A1_LSB +: REG_ADDR_WIDTH];
    assign reg2WritebackAddress_o = r_rec[A2_LSB +: REG_ADDR_WIDTH];
    assign reg1WritebackVal_o     = r_rec[V1_LSB +: DATA_WIDTH];
    assign reg2WritebackVal_o     = r_rec[V2_LSB +: DATA_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Self-checking bench for writeback_arbiter: directed vector
//                table, hand sequences for backpressure and reset, and a
//                randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;
    import writeback_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int CW = 2;
    localparam int PW = 5;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          en1;
        logic          en2;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
    } rec_t;

    typedef struct {
        logic [N-1:0] valid;
        bit           en_off;
        bit           wbr;
        bit           flush;
        int           exp_ch;
        int           exp_pend;
        logic [N-1:0] exp_ready;
    } vec_t;

    logic            clock_i = 1'b0;
    logic            reset_i;
    logic            flush_i;
    logic            wbReady_i;
    logic [N-1:0]    unitValid_i;
    logic [N-1:0]    unitReady_o;
    logic [N*CW-1:0] unitCode_i;
    logic [N-1:0]    unitReg1En_i;
    logic [N-1:0]    unitReg2En_i;
    logic [N*AW-1:0] unitReg1Addr_i;
    logic [N*AW-1:0] unitReg2Addr_i;
    logic [N*DW-1:0] unitReg1Val_i;
    logic [N*DW-1:0] unitReg2Val_i;
    logic            wbValid_o;
    logic [CW-1:0]   functionalUnitCode_o;
    logic            reg1WritebackEnable_o;
    logic            reg2WritebackEnable_o;
    logic [AW-1:0]   reg1WritebackAddress_o;
    logic [AW-1:0]   reg2WritebackAddress_o;
    logic [DW-1:0]   reg1WritebackVal_o;
    logic [DW-1:0]   reg2WritebackVal_o;
    logic [PW-1:0]   pending_o;
    rec_t            dut_rec;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model state
    rec_t m_q [N][$];
    int   m_last;
    bit   m_valid;
    rec_t m_out;

    writeback_arbiter dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .flush_i                (flush_i),
        .unitValid_i            (unitValid_i),
        .unitReady_o            (unitReady_o),
        .unitCode_i             (unitCode_i),
        .unitReg1En_i           (unitReg1En_i),
        .unitReg2En_i           (unitReg2En_i),
        .unitReg1Addr_i         (unitReg1Addr_i),
        .unitReg2Addr_i         (unitReg2Addr_i),
        .unitReg1Val_i          (unitReg1Val_i),
        .unitReg2Val_i          (unitReg2Val_i),
        .wbValid_o              (wbValid_o),
        .wbReady_i              (wbReady_i),
        .functionalUnitCode_o   (functionalUnitCode_o),
        .reg1WritebackEnable_o  (reg1WritebackEnable_o),
        .reg2WritebackEnable_o  (reg2WritebackEnable_o),
        .reg1WritebackAddress_o (reg1WritebackAddress_o),
        .reg2WritebackAddress_o (reg2WritebackAddress_o),
        .reg1WritebackVal_o     (reg1WritebackVal_o),
        .reg2WritebackVal_o     (reg2WritebackVal_o),
        .pending_o              (pending_o)
    );

    always #5 clock_i = ~clock_i;

    assign dut_rec = {functionalUnitCode_o, reg1WritebackEnable_o, reg2WritebackEnable_o,
                      reg1WritebackAddress_o, reg2WritebackAddress_o,
                      reg1WritebackVal_o, reg2WritebackVal_o};

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_chan(input int n, input logic [CW-1:0] code, input logic en1,
                            input logic en2, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [DW-1:0] v1, input logic [DW-1:0] v2);
        unitCode_i[n*CW +: CW]     = code;
        unitReg1En_i[n]            = en1;
        unitReg2En_i[n]            = en2;
        unitReg1Addr_i[n*AW +: AW] = a1;
        unitReg2Addr_i[n*AW +: AW] = a2;
        unitReg1Val_i[n*DW +: DW]  = v1;
        unitReg2Val_i[n*DW +: DW]  = v2;
    endtask

    task automatic set_idle();
        unitValid_i = '0;
        flush_i     = 1'b0;
        wbReady_i   = 1'b0;
        for (int n = 0; n < N; n++) set_chan(n, 2'(n), 1'b1, 1'b0, 6'(5 + n), '0, 64'h1234 + 64'(n), '0);
    endtask

    function automatic rec_t chan_rec(input int n);
        rec_t r;
        r.code = unitCode_i[n*CW +: CW];
        r.en1  = unitReg1En_i[n];
        r.en2  = unitReg2En_i[n];
        r.a1   = unitReg1Addr_i[n*AW +: AW];
        r.a2   = unitReg2Addr_i[n*AW +: AW];
        r.v1   = unitReg1Val_i[n*DW +: DW];
        r.v2   = unitReg2Val_i[n*DW +: DW];
        return r;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int n = 0; n < N; n++) r[n] = (m_q[n].size() < D);
        return r;
    endfunction

    function automatic int model_pending();
        int s;
        s = int'(m_valid);
        for (int n = 0; n < N; n++) s += m_q[n].size();
        return s;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) m_q[n].delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_last  = N - 1;
    endtask

    // One clock edge of the reference behaviour, using pre-edge occupancy.
    task automatic model_edge();
        logic [N-1:0] rdy;
        int g;
        int c;
        if (flush_i) begin
            for (int n = 0; n < N; n++) m_q[n].delete();
            m_valid = 1'b0;
            m_out   = '0;
            return;
        end
        rdy = model_ready();
        if (!m_valid || wbReady_i) begin
            g = -1;
            for (int i = 1; i <= N; i++) begin
                c = (m_last + i) % N;
                if (g < 0 && m_q[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_out   = m_q[g].pop_front();
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int n = 0; n < N; n++)
            if (unitValid_i[n] && rdy[n] && (unitReg1En_i[n] || unitReg2En_i[n]))
                m_q[n].push_back(chan_rec(n));
    endtask

    task automatic check_model();
        chk("ready", unitReady_o, model_ready());
        chk("wbValid", wbValid_o, m_valid);
        chk("pending", pending_o, model_pending());
        if (m_valid) chk("record", dut_rec, m_out);
    endtask

    // Called at posedge+1; returns at posedge+1 with outputs checked.
    task automatic step();
        @(posedge clock_i);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset asserted between edges, held over one edge.
    task automatic do_reset();
        #2 reset_i = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", wbValid_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_ready", unitReady_o, 4'hF);
        chk("rst_record", dut_rec, 0);
        @(posedge clock_i);
        #1 reset_i = 1'b1;
    endtask

    vec_t tbl [17];
    rec_t got [$];

    initial begin
        int k;
        int c;
        bit hs;
        tbl[0]  = '{4'b1111, 0, 1, 0, -1, 4, 4'hF};
        tbl[1]  = '{4'b0000, 0, 1, 0,  0, 4, 4'hF};
        tbl[2]  = '{4'b0000, 0, 1, 0,  1, 3, 4'hF};
        tbl[3]  = '{4'b0000, 0, 1, 0,  2, 2, 4'hF};
        tbl[4]  = '{4'b0000, 0, 1, 0,  3, 1, 4'hF};
        tbl[5]  = '{4'b0000, 0, 1, 0, -1, 0, 4'hF};
        tbl[6]  = '{4'b0001, 0, 1, 0, -1, 1, 4'hF};
        tbl[7]  = '{4'b0000, 0, 0, 0,  0, 1, 4'hF};
        tbl[8]  = '{4'b0000, 0, 0, 0,  0, 1, 4'hF};
        tbl[9]  = '{4'b0000, 0, 0, 0,  0, 1, 4'hF};
        tbl[10] = '{4'b0000, 0, 0, 0,  0, 1, 4'hF};
        tbl[11] = '{4'b0000, 0, 1, 0, -1, 0, 4'hF};
        tbl[12] = '{4'b0001, 1, 1, 0, -1, 0, 4'hF};
        tbl[13] = '{4'b0000, 0, 1, 0, -1, 0, 4'hF};
        tbl[14] = '{4'b1111, 0, 0, 0, -1, 4, 4'hF};
        tbl[15] = '{4'b0011, 0, 0, 0,  1, 6, 4'hF};
        tbl[16] = '{4'b1111, 0, 0, 1, -1, 0, 4'hF};

        reset_i = 1'b1;
        set_idle();
        @(posedge clock_i);
        #1;
        do_reset();

        // Directed vector table
        for (int r = 0; r < 17; r++) begin
            for (int n = 0; n < N; n++)
                set_chan(n, 2'(n), !tbl[r].en_off, 1'b0, 6'(5 + n), '0, 64'h1234 + 64'(n), '0);
            unitValid_i = tbl[r].valid;
            wbReady_i   = tbl[r].wbr;
            flush_i     = tbl[r].flush;
            step();
            chk($sformatf("tbl%0d_valid", r), wbValid_o, (tbl[r].exp_ch >= 0));
            chk($sformatf("tbl%0d_pending", r), pending_o, tbl[r].exp_pend);
            chk($sformatf("tbl%0d_ready", r), unitReady_o, tbl[r].exp_ready);
            if (tbl[r].exp_ch >= 0) begin
                chk($sformatf("tbl%0d_code", r), functionalUnitCode_o, tbl[r].exp_ch);
                chk($sformatf("tbl%0d_addr1", r), reg1WritebackAddress_o, 5 + tbl[r].exp_ch);
                chk($sformatf("tbl%0d_val1", r), reg1WritebackVal_o, 64'h1234 + 64'(tbl[r].exp_ch));
            end
        end
        set_idle();

        // Reset with six records in flight, then first grant goes to channel 0
        unitValid_i = 4'b1111;
        step();
        unitValid_i = 4'b0011;
        step();
        chk("pre_reset_pending", pending_o, 6);
        do_reset();
        unitValid_i = 4'b1111;
        wbReady_i   = 1'b1;
        step();
        unitValid_i = 4'b0000;
        step();
        chk("post_reset_valid", wbValid_o, 1);
        chk("post_reset_code", functionalUnitCode_o, UNIT_FX);
        chk("post_reset_addr1", reg1WritebackAddress_o, 5);

        // Channel 2 backpressure with the output register already occupied
        set_idle();
        do_reset();
        unitValid_i = 4'b0001;
        step();
        unitValid_i = 4'b0000;
        step();
        k = 0;
        for (c = 0; c < 6; c++) begin
            set_chan(2, UNIT_LDST, 1'b1, 1'b0, 6'(10 + k), '0, 64'hA000 + 64'(k), '0);
            unitValid_i = 4'b0100;
            hs = unitReady_o[2];
            step();
            if (hs) k++;
        end
        chk("q2_ready_low", unitReady_o[2], 0);
        chk("q2_pending", pending_o, 5);
        chk("q2_accepted", k, 4);
        wbReady_i = 1'b1;
        for (c = 0; c < 10 && k < 5; c++) begin
            set_chan(2, UNIT_LDST, 1'b1, 1'b0, 6'(10 + k), '0, 64'hA000 + 64'(k), '0);
            unitValid_i = 4'b0100;
            hs = unitReady_o[2];
            step();
            if (hs) k++;
            if (wbValid_o && functionalUnitCode_o == UNIT_LDST) got.push_back(dut_rec);
        end
        chk("q2_fifth_accepted", k, 5);
        unitValid_i = 4'b0000;
        for (c = 0; c < 8; c++) begin
            step();
            if (wbValid_o && functionalUnitCode_o == UNIT_LDST) got.push_back(dut_rec);
        end
        chk("q2_drain_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) begin
            chk($sformatf("q2_order_a1_%0d", i), got[i].a1, 10 + i);
            chk($sformatf("q2_order_v1_%0d", i), got[i].v1, 64'hA000 + 64'(i));
        end

        // Randomized traffic against the reference model
        set_idle();
        do_reset();
        for (c = 0; c < 400; c++) begin
            for (int n = 0; n < N; n++)
                set_chan(n, 2'($urandom_range(0, 3)), ($urandom % 4) != 0, ($urandom % 2) != 0,
                         6'($urandom), 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            unitValid_i = 4'($urandom);
            wbReady_i   = ((c % 100) < 30) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            flush_i     = ($urandom % 50) == 0;
            step();
        end
        set_idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
